key_cmd_decoder: RTL and testbench

Translates the PS/2 keyboard event word into per-player game commands (rotate/left/right/down pulses) and global system controls (music, run/pause, start, soft reset) for the Tetris top level. It generalises the top-level key decode to 1–4 players and adds hold-to-repeat with programmable delay and rate. It sits between `keyboard` and the `player` instances, and its outputs drive `player`, `TIMER` and `MUSIC`.

---
 rtl/key_cmd_pkg.sv | 43 ++++
 rtl/key_cmd_decoder_if.sv | 23 ++
 rtl/key_repeat_unit.sv | 63 ++++++
 rtl/key_cmd_decoder.sv | 134 +++++++++++++
 tb/tb_key_cmd_decoder.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_cmd_pkg.sv
// Shared definitions for the keyboard command decoder: scan codes, the
// per-player keymap and the enums used by the decoder and its repeat units.
package key_cmd_pkg;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_I     = 8'h43;
  localparam logic [7:0] SC_J     = 8'h3B;
  localparam logic [7:0] SC_K     = 8'h42;
  localparam logic [7:0] SC_L     = 8'h4B;
  localparam logic [7:0] SC_KP8   = 8'h75;
  localparam logic [7:0] SC_KP4   = 8'h6B;
  localparam logic [7:0] SC_KP5   = 8'h73;
  localparam logic [7:0] SC_KP6   = 8'h74;
  localparam logic [7:0] SC_M     = 8'h3A;
  localparam logic [7:0] SC_P     = 8'h4D;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_R     = 8'h2D;

  typedef struct packed {
    logic       e0;
    logic [7:0] code;
  } key_t;

  typedef enum logic [1:0] {ROT = 2'd0, LEFT = 2'd1, DOWN = 2'd2, RIGHT = 2'd3} dir_e;

  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, RATE = 2'd2} rpt_state_e;

  // Indexed [player][dir_e]; the extended flag must match exactly.
  localparam key_t KEYMAP [4][4] = '{
    '{key_t'{1'b0, SC_W},   key_t'{1'b0, SC_A},    key_t'{1'b0, SC_S},    key_t'{1'b0, SC_D}},
    '{key_t'{1'b1, SC_UP},  key_t'{1'b1, SC_LEFT}, key_t'{1'b1, SC_DOWN}, key_t'{1'b1, SC_RIGHT}},
    '{key_t'{1'b0, SC_I},   key_t'{1'b0, SC_J},    key_t'{1'b0, SC_K},    key_t'{1'b0, SC_L}},
    '{key_t'{1'b0, SC_KP8}, key_t'{1'b0, SC_KP4},  key_t'{1'b0, SC_KP5},  key_t'{1'b0, SC_KP6}}
  };

endpackage

// File: rtl/key_cmd_decoder_if.sv
// Bundle between the keyboard front end and the command decoder outputs.
interface key_cmd_decoder_if #(parameter int NUM_PLAYERS = 2);

  // key_event is a level word with no back-pressure: a new event is seen when
  // valid rises or when the word changes while valid stays high.
  logic [10:0]              key_event;
  logic [NUM_PLAYERS-1:0]   rot;
  logic [NUM_PLAYERS-1:0]   left;
  logic [NUM_PLAYERS-1:0]   right;
  logic [NUM_PLAYERS-1:0]   down;
  logic                     music;
  logic                     run;
  logic                     started;
  logic                     soft_rstn;
  logic [6*NUM_PLAYERS-1:0] rep_state;

  modport master (output key_event,
                  input  rot, left, right, down, music, run, started, soft_rstn, rep_state);

  modport slave  (input  key_event,
                  output rot, left, right, down, music, run, started, soft_rstn, rep_state);

endinterface

// File: rtl/key_repeat_unit.sv
// Hold-to-repeat generator for one key: pulse on press, again after DELAY
// ticks, then every RATE ticks until release or cancel.
module key_repeat_unit #(
  parameter int DELAY = 250,
  parameter int RATE  = 50
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       press,
  input  logic       release_key,
  input  logic       cancel,
  input  logic       tick,
  output logic       pulse,
  output logic [1:0] state
);

  localparam int LIMIT_MAX = (DELAY > RATE) ? DELAY : RATE;
  localparam int CW        = $clog2(LIMIT_MAX + 1);

  key_cmd_pkg::rpt_state_e st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc, limit;
  logic          pulse_d;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign limit   = (st_q == key_cmd_pkg::DELAY) ? CW'(DELAY) : CW'(RATE);
  assign state   = st_q;

  // Press outranks release/cancel, which outrank a tick in the same cycle.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (press) begin
      pulse_d = 1'b1;
      cnt_d   = '0;
      st_d    = key_cmd_pkg::DELAY;
    end else if (release_key || cancel) begin
      cnt_d = '0;
      st_d  = key_cmd_pkg::IDLE;
    end else if (tick && st_q != key_cmd_pkg::IDLE) begin
      if (cnt_inc == limit) begin
        pulse_d = 1'b1;
        cnt_d   = '0;
        st_d    = key_cmd_pkg::RATE;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q  <= key_cmd_pkg::IDLE;
      cnt_q <= '0;
      pulse <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      pulse <= pulse_d;
    end
  end

endmodule

// File: rtl/key_cmd_decoder.sv
// Decodes keyboard events into per-player game command pulses with
// hold-to-repeat, plus the global music/run/start/soft-reset controls.
module key_cmd_decoder
  import key_cmd_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int CLK_HZ          = 100_000_000,
  parameter int REPEAT_DELAY_MS = 250,
  parameter int REPEAT_RATE_MS  = 50
) (
  input  logic clk,
  input  logic rstn,
  key_cmd_decoder_if.slave bus
);

  localparam int TICK_CYCLES = CLK_HZ / 1000;
  localparam int PW          = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic          prev_valid;
  logic [9:0]    prev_word;
  logic          accept;
  logic          sys_make;
  logic [NUM_PLAYERS-1:0][3:0] make_hit;
  logic [NUM_PLAYERS-1:0][3:1] brk_hit;
  logic [NUM_PLAYERS-1:0][3:1] rpt_pulse;
  logic [NUM_PLAYERS-1:0]      rot_q;
  logic music_q, run_q, started_q, soft_rstn_q;

  assign tick = (presc == PW'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Keyboard typematic re-sends repeat the same word, so they are dropped here.
  assign accept   = bus.key_event[10] && (!prev_valid || bus.key_event[9:0] != prev_word);
  assign sys_make = accept && !bus.key_event[9] && !bus.key_event[8];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_valid <= 1'b0;
      prev_word  <= '0;
    end else begin
      prev_valid <= bus.key_event[10];
      prev_word  <= bus.key_event[9:0];
    end
  end

  always_comb begin
    make_hit = '0;
    brk_hit  = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int d = 0; d < 4; d++)
        if (accept && !bus.key_event[8] &&
            {bus.key_event[9], bus.key_event[7:0]} == KEYMAP[p][d])
          make_hit[p][d] = 1'b1;
      for (int d = 1; d < 4; d++)
        if (accept && bus.key_event[8] &&
            {bus.key_event[9], bus.key_event[7:0]} == KEYMAP[p][d])
          brk_hit[p][d] = 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    for (genvar d = 1; d < 4; d++) begin : g_dir
      logic cancel;
      if (d == int'(LEFT)) begin : g_l
        assign cancel = make_hit[p][RIGHT];
      end else if (d == int'(RIGHT)) begin : g_r
        assign cancel = make_hit[p][LEFT];
      end else begin : g_n
        assign cancel = 1'b0;
      end

      key_repeat_unit #(
        .DELAY (REPEAT_DELAY_MS),
        .RATE  (REPEAT_RATE_MS)
      ) u_rpt (
        .clk         (clk),
        .rstn        (rstn),
        .press       (make_hit[p][d]),
        .release_key (brk_hit[p][d]),
        .cancel      (cancel),
        .tick        (tick),
        .pulse       (rpt_pulse[p][d]),
        .state       (bus.rep_state[(p*3 + d - 1)*2 +: 2])
      );
    end

    assign bus.left[p]  = rpt_pulse[p][LEFT];
    assign bus.down[p]  = rpt_pulse[p][DOWN];
    assign bus.right[p] = rpt_pulse[p][RIGHT];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rot_q       <= '0;
      music_q     <= 1'b0;
      run_q       <= 1'b0;
      started_q   <= 1'b0;
      soft_rstn_q <= 1'b1;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) rot_q[p] <= make_hit[p][ROT];
      soft_rstn_q <= 1'b1;
      if (sys_make) begin
        case (bus.key_event[7:0])
          SC_M:     music_q <= ~music_q;
          SC_P:     run_q   <= 1'b0;
          SC_SPACE: begin
            run_q     <= 1'b1;
            started_q <= 1'b1;
          end
          SC_R:     begin
            run_q       <= 1'b0;
            started_q   <= 1'b0;
            soft_rstn_q <= 1'b0;
          end
          default:  ;
        endcase
      end
    end
  end

  assign bus.rot       = rot_q;
  assign bus.music     = music_q;
  assign bus.run       = run_q;
  assign bus.started   = started_q;
  assign bus.soft_rstn = soft_rstn_q;

endmodule

// File: tb/tb_key_cmd_decoder.sv
// Bench for key_cmd_decoder: directed table, timed repeat sequences and
// random events checked every cycle against a tick-counting reference model.
module tb_key_cmd_decoder;

  localparam int NP       = 2;
  localparam int CLK_HZ   = 10_000;
  localparam int DLY      = 3;
  localparam int RTE      = 2;
  localparam int TICK_CYC = CLK_HZ / 1000;
  localparam int W        = 4*NP + 4;
  localparam logic [W-1:0] RST_VEC = W'(1);

  // {e0, code} per player, columns rot, left, down, right.
  localparam logic [8:0] KM [4][4] = '{
    '{9'h01D, 9'h01C, 9'h01B, 9'h023},
    '{9'h175, 9'h16B, 9'h172, 9'h174},
    '{9'h043, 9'h03B, 9'h042, 9'h04B},
    '{9'h075, 9'h06B, 9'h073, 9'h074}
  };
  localparam logic [8:0] POOL [16] = '{
    9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h175, 9'h16B, 9'h172, 9'h174,
    9'h075, 9'h073, 9'h03A, 9'h04D, 9'h029, 9'h02D, 9'h055, 9'h11C
  };

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  key_cmd_decoder_if #(.NUM_PLAYERS(NP)) bus ();

  key_cmd_decoder #(
    .NUM_PLAYERS     (NP),
    .CLK_HZ          (CLK_HZ),
    .REPEAT_DELAY_MS (DLY),
    .REPEAT_RATE_MS  (RTE)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model + scoreboard ----------------
  int          edges;
  logic        m_prev_v;
  logic [9:0]  m_prev_w;
  bit          held [NP][4];
  int          nt   [NP][4];
  bit          mk   [NP][4];
  bit          bk   [NP][4];
  logic        m_music, m_run, m_started;
  logic [NP-1:0] e_rot, e_left, e_right, e_down;
  logic        e_srst, m_tick, m_acc;
  logic [10:0] m_ev;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_act, sb_exp;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      edges = 0; m_prev_v = 1'b0; m_prev_w = '0;
      m_music = 1'b0; m_run = 1'b0; m_started = 1'b0;
      for (int p = 0; p < NP; p++)
        for (int d = 0; d < 4; d++) begin held[p][d] = 1'b0; nt[p][d] = 0; end
      exp_q.delete();
    end else begin
      m_tick = (edges % TICK_CYC) == TICK_CYC - 1;
      edges++;
      m_ev  = bus.key_event;
      m_acc = m_ev[10] && (!m_prev_v || m_ev[9:0] != m_prev_w);
      m_prev_v = m_ev[10];
      m_prev_w = m_ev[9:0];
      e_rot = '0; e_left = '0; e_right = '0; e_down = '0; e_srst = 1'b1;
      for (int p = 0; p < NP; p++)
        for (int d = 0; d < 4; d++) begin
          mk[p][d] = m_acc && !m_ev[8] && {m_ev[9], m_ev[7:0]} == KM[p][d];
          bk[p][d] = m_acc &&  m_ev[8] && {m_ev[9], m_ev[7:0]} == KM[p][d];
        end
      for (int p = 0; p < NP; p++) begin
        e_rot[p] = mk[p][0];
        for (int d = 1; d < 4; d++) begin
          int  opp;
          bit  fire;
          opp  = (d == 1) ? 3 : (d == 3) ? 1 : 0;
          fire = 1'b0;
          if (mk[p][d]) begin
            held[p][d] = 1'b1; nt[p][d] = 0; fire = 1'b1;
          end else if (bk[p][d] || (opp != 0 && mk[p][opp])) begin
            held[p][d] = 1'b0;
          end else if (held[p][d] && m_tick) begin
            nt[p][d]++;
            fire = nt[p][d] >= DLY && ((nt[p][d] - DLY) % RTE) == 0;
          end
          if (d == 1) e_left[p]  = fire;
          if (d == 2) e_down[p]  = fire;
          if (d == 3) e_right[p] = fire;
        end
      end
      if (m_acc && !m_ev[9] && !m_ev[8]) begin
        case (m_ev[7:0])
          8'h3A: m_music = !m_music;
          8'h4D: m_run = 1'b0;
          8'h29: begin m_run = 1'b1; m_started = 1'b1; end
          8'h2D: begin m_run = 1'b0; m_started = 1'b0; e_srst = 1'b0; end
          default: ;
        endcase
      end
      exp_q.push_back({e_rot, e_left, e_right, e_down, m_music, m_run, m_started, e_srst});
    end
  end

  always @(negedge clk) begin
    sb_act = {bus.rot, bus.left, bus.right, bus.down, bus.music, bus.run, bus.started, bus.soft_rstn};
    if (!rstn || exp_q.size() == 0) sb_exp = RST_VEC;
    else sb_exp = exp_q.pop_front();
    check("scoreboard", 32'(sb_act), 32'(sb_exp));
  end

  // ---------------- driver helpers ----------------
  int cnt_a [4];
  int first_a [4];
  int second_a [4];

  function automatic logic out_bit(int p, int d);
    case (d)
      0:       return bus.rot[p];
      1:       return bus.left[p];
      2:       return bus.down[p];
      default: return bus.right[p];
    endcase
  endfunction

  // Sample n negedges, recording pulse count and first/second pulse index per direction.
  task automatic count_pulses(int n, int p);
    for (int d = 0; d < 4; d++) begin cnt_a[d] = 0; first_a[d] = -1; second_a[d] = -1; end
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++)
        if (out_bit(p, d)) begin
          cnt_a[d]++;
          if (cnt_a[d] == 1) first_a[d] = s;
          if (cnt_a[d] == 2) second_a[d] = s;
        end
    end
  endtask

  // Leave the bench at a negedge where the next posedge is a prescaler-phase-0 edge.
  task automatic align_tick();
    @(negedge clk);
    for (int i = 0; i < TICK_CYC && (edges % TICK_CYC) != 0; i++) @(negedge clk);
  endtask

  typedef struct {
    string         name;
    logic [10:0]   ev;
    logic [NP-1:0] rot;
    logic          music;
    logic          run;
    logic          started;
    logic          srst;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{"space",      11'h429, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{"m_on",       11'h43A, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{"m_break",    11'h53A, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{"m_off",      11'h43A, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{"w_rot",      11'h41D, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{"up_rot_p1",  11'h675, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{"kp8_ignore", 11'h475, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{"pause",      11'h44D, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{"space2",     11'h429, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{"r_reset",    11'h42D, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{"unmapped",   11'h455, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{"space_e0",   11'h629, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};

    bus.key_event = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({bus.rot, bus.left, bus.right, bus.down,
                                bus.music, bus.run, bus.started, bus.soft_rstn}), 32'(RST_VEC));
    #2 rstn = 1'b1;

    // Directed table: one event, check next cycle, then an idle cycle.
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      bus.key_event = tbl[i].ev;
      @(negedge clk);
      check({tbl[i].name, "_rot"},     32'(bus.rot),       32'(tbl[i].rot));
      check({tbl[i].name, "_music"},   32'(bus.music),     32'(tbl[i].music));
      check({tbl[i].name, "_run"},     32'(bus.run),       32'(tbl[i].run));
      check({tbl[i].name, "_started"}, 32'(bus.started),   32'(tbl[i].started));
      check({tbl[i].name, "_srst"},    32'(bus.soft_rstn), 32'(tbl[i].srst));
      bus.key_event = '0;
      @(negedge clk);
      check({tbl[i].name, "_rot_idle"},  32'(bus.rot),       32'(0));
      check({tbl[i].name, "_srst_idle"}, 32'(bus.soft_rstn), 32'(1));
    end

    // W held valid for 5 cycles: a single rotate pulse, no repeat.
    bus.key_event = 11'h41D;
    count_pulses(5, 0);
    check("w_hold_rot_count", 32'(cnt_a[0]), 32'(1));
    check("w_hold_rot_first", 32'(first_a[0]), 32'(0));
    bus.key_event = 11'h51D;
    count_pulses(3, 0);

    // A held 100 cycles: pulse at once, after 3 ticks, then every 2 ticks.
    align_tick();
    bus.key_event = 11'h41C;
    count_pulses(100, 0);
    check("a_left_count",  32'(cnt_a[1]),    32'(5));
    check("a_left_first",  32'(first_a[1]),  32'(0));
    check("a_left_second", 32'(second_a[1]), 32'(29));
    bus.key_event = 11'h51C;
    count_pulses(50, 0);
    check("a_after_break", 32'(cnt_a[1]), 32'(0));

    // Hold A, then D: left is cancelled and only right repeats.
    bus.key_event = '0;
    align_tick();
    bus.key_event = 11'h41C;
    count_pulses(40, 0);
    check("ad_left_before", 32'(cnt_a[1]), 32'(2));
    bus.key_event = 11'h423;
    count_pulses(60, 0);
    check("ad_left_after",   32'(cnt_a[3 - 2]), 32'(0));
    check("ad_right_count",  32'(cnt_a[3]),     32'(3));
    check("ad_right_first",  32'(first_a[3]),   32'(0));
    check("ad_right_second", 32'(second_a[3]),  32'(29));
    bus.key_event = 11'h523;
    count_pulses(20, 0);
    bus.key_event = 11'h51C;
    count_pulses(20, 0);
    check("ad_quiet", 32'(cnt_a[1] + cnt_a[3]), 32'(0));

    // Reset while S is held: levels clear, no down pulses until a new make.
    bus.key_event = 11'h429;
    count_pulses(2, 0);
    bus.key_event = 11'h43A;
    count_pulses(2, 0);
    bus.key_event = '0;
    align_tick();
    bus.key_event = 11'h41B;
    count_pulses(35, 0);
    check("s_down_before", 32'(cnt_a[2]), 32'(2));
    #2 rstn = 1'b0;
    bus.key_event = '0;
    @(negedge clk);
    check("rst_music",   32'(bus.music),     32'(0));
    check("rst_run",     32'(bus.run),       32'(0));
    check("rst_started", 32'(bus.started),   32'(0));
    check("rst_srst",    32'(bus.soft_rstn), 32'(1));
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    count_pulses(60, 0);
    check("s_down_after_reset", 32'(cnt_a[2]), 32'(0));
    bus.key_event = 11'h41B;
    count_pulses(5, 0);
    check("s_new_make", 32'(cnt_a[2]), 32'(1));
    bus.key_event = 11'h51B;
    count_pulses(3, 0);

    // Random events with random hold times, checked by the scoreboard.
    for (int i = 0; i < 200; i++) begin
      logic [8:0]  k;
      logic [10:0] ev;
      k  = POOL[$urandom_range(0, 15)];
      ev = {1'b1, k[8], ($urandom_range(0, 2) == 0), k[7:0]};
      if ($urandom_range(0, 5) == 0) ev = '0;
      bus.key_event = ev;
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    bus.key_event = '0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
